// File: rtl/frame_sequencer.sv
// Selects which of four frame sources drives the registered VGA RGB output. Frame changes take effect only at frame boundaries.
// Define FRAME_SEQ_FADE_EN to add a fade-out/fade-in transition around each frame change.
module frame_sequencer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int NUM_FRAMES  = 4,
    parameter int FADE_STEPS  = 8,
    parameter int RESET_FRAME = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [9:0]  i_x,
    input  logic [8:0]  i_y,
    input  logic        i_frame_end,
    input  logic        i_req_valid,
    input  logic [1:0]  i_req_frame,
    output logic        o_req_ready,
    input  logic [23:0] i_rgb_0,
    input  logic [23:0] i_rgb_1,
    input  logic [23:0] i_rgb_2,
    input  logic [23:0] i_rgb_3,
    output logic [23:0] o_rgb,
    output logic [1:0]  o_frame_sel,
    output logic        o_busy
);

    localparam int FRAME_W = $clog2(NUM_FRAMES);
    localparam int SHIFT   = $clog2(FADE_STEPS);
    localparam int LVL_W   = SHIFT + 1;

    localparam logic [9:0]         H_LIM     = 10'(H_ACTIVE);
    localparam logic [8:0]         V_LIM     = 9'(V_ACTIVE);
    localparam logic [FRAME_W-1:0] RST_SEL   = FRAME_W'(RESET_FRAME);
    localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(FADE_STEPS);
    localparam logic [LVL_W-1:0]   LVL_ONE   = LVL_W'(1);

`ifdef FRAME_SEQ_FADE_EN
    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;
    logic [LVL_W-1:0] level, level_d;
`else
    typedef enum logic [0:0] {IDLE, PEND} state_t;
    wire  [LVL_W-1:0] level = LVL_FULL;
`endif

    state_t             state, state_d;
    logic [FRAME_W-1:0] sel, sel_d;
    logic [FRAME_W-1:0] pend, pend_d;
    logic [23:0]        rgb_q;
    logic [23:0]        src_rgb;
    logic               blank;

    // Each 8-bit channel is scaled by level/FADE_STEPS with a 13-bit product.
    function automatic logic [23:0] scale(input logic [23:0] c, input logic [LVL_W-1:0] lvl);
        logic [12:0] prod;
        logic [23:0] res;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            prod = 13'(c[8*k +: 8]) * 13'(lvl);
            res[8*k +: 8] = 8'(prod >> SHIFT);
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state;
        sel_d   = sel;
        pend_d  = pend;
`ifdef FRAME_SEQ_FADE_EN
        level_d = level;
`endif
        unique case (state)
            IDLE: begin
                // A frame-end pulse arriving with the request is deliberately not consumed here.
                if (i_req_valid) begin
                    pend_d = i_req_frame;
`ifdef FRAME_SEQ_FADE_EN
                    if (i_req_frame != sel) state_d = FADE_OUT;
`else
                    if (i_req_frame != sel) state_d = PEND;
`endif
                end
            end
`ifdef FRAME_SEQ_FADE_EN
            FADE_OUT: begin
                if (i_frame_end) begin
                    level_d = level - LVL_ONE;
                    if (level == LVL_ONE) begin
                        sel_d   = pend;
                        state_d = FADE_IN;
                    end
                end
            end
            FADE_IN: begin
                if (i_frame_end) begin
                    level_d = level + LVL_ONE;
                    if (level + LVL_ONE == LVL_FULL) state_d = IDLE;
                end
            end
`else
            PEND: begin
                if (i_frame_end) begin
                    sel_d   = pend;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_rgb = i_rgb_0;
        case (sel)
            2'd0:    src_rgb = i_rgb_0;
            2'd1:    src_rgb = i_rgb_1;
            2'd2:    src_rgb = i_rgb_2;
            default: src_rgb = i_rgb_3;
        endcase
        blank = (i_x >= H_LIM) || (i_y >= V_LIM);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            state <= IDLE;
            sel   <= RST_SEL;
            pend  <= RST_SEL;
            rgb_q <= '0;
`ifdef FRAME_SEQ_FADE_EN
            level <= LVL_FULL;
`endif
        end else begin
            state <= state_d;
            sel   <= sel_d;
            pend  <= pend_d;
            rgb_q <= blank ? 24'h0 : scale(src_rgb, level);
`ifdef FRAME_SEQ_FADE_EN
            level <= level_d;
`endif
        end
    end

    assign o_rgb       = rgb_q;
    assign o_frame_sel = sel;
    assign o_busy      = (state != IDLE);
    assign o_req_ready = (state == IDLE);

endmodule
